// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
// The optional ovf signal is present only when SERIAL_ADDER_OVF_EN is defined.
// master = operand producer / result consumer, slave = the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, cout, done_valid, busy, ovf
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, cout, done_valid, busy, ovf
  );
`else
  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, cout, done_valid, busy
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, cout, done_valid, busy
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (WIDTH legal range 1..32).
// One full-adder slice (two half-adder stages plus a registered carry) is
// evaluated per clock, LSB first, so an add takes WIDTH RUN cycles.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed
// two's-complement overflow output ovf on the interface.
// The interface instance must be built with the same WIDTH as this module.
//
// state | meaning
// IDLE  | waiting for operands, start_ready=1
// RUN   | one bit processed per cycle, busy=1
// DONE  | result presented, done_valid=1, waiting for done_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_sr_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             s1;
  logic             c1;
  logic             s;
  logic             c2;
  logic             carry_nxt;

  logic             accept;
  logic             last;
  logic             done_hs;

  assign accept  = bus.start_valid && (state == IDLE);
  assign last    = (state == RUN) && (cnt == LAST_BIT);
  assign done_hs = (state == DONE) && bus.done_ready;

  // Full-adder slice: first half adder on the operand bits, second half
  // adder folds in the registered carry.
  always_comb begin
    ai         = a_sr[0];
    bi         = b_sr[0];
    s1         = ai ^ bi;
    c1         = ai & bi;
    s          = s1 ^ carry;
    c2         = s1 & carry;
    carry_nxt  = c1 | c2;
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
    sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    if (done_hs) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand/sum shift registers, carry, bit counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
      sum_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= carry_nxt;
      cnt    <= cnt + CW'(1);
      sum_sr <= sum_sr_nxt;
      // The visible result only moves on the RUN->DONE step.
      if (last) begin
        sum_q  <= sum_sr_nxt;
        cout_q <= carry_nxt;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the MSB slice the registered carry is the carry into the MSB and
  // carry_nxt the carry out; their XOR is signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= carry ^ carry_nxt;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.done_valid  = (state == DONE);
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// Expected results come from integer arithmetic on the operands and are
// queued at accept; a monitor pops and compares on every result handshake.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad = 0;
  int issued = 0;
  int handshakes = 0;
  bit rand_ready = 1'b0;

  exp_t exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t r;
    int   u;
    int   sv;
    u      = int'(x) + int'(y) + int'(c);
    sv     = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.sum  = W'(u % 256);
    r.cout = (u >= 256);
    r.ovf  = (sv > 127) || (sv < -128);
    return r;
  endfunction

  // Offer operands, wait (bounded) for the accept edge, queue the expectation.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int n;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a   = ia;
    bus.b   = ib;
    bus.cin = ic;
    n = 0;
    while (!bus.start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_seen", {31'd0, bus.start_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(ia, ib, ic));
    issued++;
    #1;
    bus.start_valid = 1'b0;
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
  endtask

  // Count edges after the accept until done_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", {31'd0, bus.done_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.start_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_seen", {31'd0, bus.start_ready}, 32'd1);
  endtask

  // Scoreboard monitor: a handshake completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done_valid && bus.done_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got sum=%0h required no result", bus.sum);
        end else begin
          e = exp_q.pop_front();
          handshakes++;
          check("sb_sum", {24'd0, bus.sum}, {24'd0, e.sum});
          check("sb_cout", {31'd0, bus.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
          check("sb_ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
        end
      end
    end
  end

  // Randomised consumer backpressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.done_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic ra;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.cin         = 1'b0;
    bus.done_ready  = 1'b1;

    #2;
    check("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("rst_sum", {24'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 0x5A + 0x3C: latency and single-cycle done_valid with ready high.
    start_op(8'h5A, 8'h3C, 1'b0);
    check("run_busy", {31'd0, bus.busy}, 32'd1);
    check("run_start_ready", {31'd0, bus.start_ready}, 32'd0);
    wait_done(lat);
    check("latency", lat, W);
    check("d1_sum", {24'd0, bus.sum}, 32'h96);
    check("d1_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("d1_ovf", {31'd0, bus.ovf}, 32'd1);
`endif
    @(posedge clk);
    #1;
    check("one_cycle_done", {31'd0, bus.done_valid}, 32'd0);
    check("ready_after_hs", {31'd0, bus.start_ready}, 32'd1);

    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(lat);
    check("d2_sum", {24'd0, bus.sum}, 32'h00);
    check("d2_cout", {31'd0, bus.cout}, 32'd1);
    wait_idle();

    // Backpressure on 0xFF + 0xFF + 1.
    bus.done_ready = 1'b0;
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(lat);
    held_sum = bus.sum;
    check("d3_sum", {24'd0, held_sum}, 32'hFF);
    check("d3_cout", {31'd0, bus.cout}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("d3_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_done_valid", {31'd0, bus.done_valid}, 32'd1);
      check("bp_start_ready", {31'd0, bus.start_ready}, 32'd0);
      check("bp_sum_hold", {24'd0, bus.sum}, 32'hFF);
      check("bp_cout_hold", {31'd0, bus.cout}, 32'd1);
    end
    bus.done_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", {31'd0, bus.start_ready}, 32'd1);
    check("bp_release_done", {31'd0, bus.done_valid}, 32'd0);

    // Start request during RUN must be ignored.
    start_op(8'h5A, 8'h3C, 1'b0);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    wait_done(lat);
    check("ign_sum", {24'd0, bus.sum}, 32'h96);
    wait_idle();

    // Reset after three RUN cycles aborts the add.
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_start_ready", {31'd0, bus.start_ready}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done_valid", {31'd0, bus.done_valid}, 32'd0);
    check("abort_sum", {24'd0, bus.sum}, 32'd0);
    check("abort_cout", {31'd0, bus.cout}, 32'd0);
    issued = issued - exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(lat);
    check("post_abort_sum", {24'd0, bus.sum}, 32'h02);
    check("post_abort_cout", {31'd0, bus.cout}, 32'd0);
    wait_idle();

    // Random operands with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      ra = 1'($urandom);
      if (i == 0) begin rx = 8'h80; ry = 8'h80; end
      if (i == 1) begin rx = 8'h7F; ry = 8'h00; ra = 1'b1; end
      start_op(rx, ry, ra);
      wait_done(lat);
      check("rand_latency", lat, W);
      wait_idle();
    end
    rand_ready = 1'b0;
    bus.done_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("sb_queue_empty", exp_q.size(), 32'd0);
    check("sb_handshakes", handshakes, issued);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
